noc_link_credit_buffer: RTL and testbench



---
 rtl/noc_link_credit_buffer.sv | 165 ++++++++++++++++
 tb/tb_noc_link_credit_buffer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_link_credit_buffer.sv
// ---------------------------------------------------------------------------
// noc_link_credit_buffer
//
// Elastic link stage between two routers. Flits from the upstream router go
// into a local FIFO. Each flit popped from the FIFO returns one credit
// upstream. Popped flits are forwarded downstream under a local credit
// counter that mirrors the free space of the downstream router's input
// buffer. Optional register stages after the output register carry long wires.
//
// Handshake: send_in/send_out are single-cycle valids. There is no ready
// signal. Flow control is purely credit based. credit_out/credit_in are
// single-cycle pulses, and each pulse is worth exactly one buffer slot.
//
// Optional feature: define LINK_STATS_EN to build the flit/packet counters.
// Without it, flit_count and pkt_count are tied to zero.
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   data_in/dest_in/is_tail_in/send_in    flit from upstream router
//   credit_out                one pulse per FIFO slot freed (pop)
//   data_out/dest_out/is_tail_out/send_out flit to downstream router
//   credit_in                 one pulse per downstream slot freed
//   occupancy                 FIFO entries in use
//   overflow_err              sticky: flit arrived while FIFO full (dropped)
//   credit_err                sticky: credit returned while counter at max
//   flit_count/pkt_count      forwarded flits / tails (LINK_STATS_EN)
// ---------------------------------------------------------------------------
module noc_link_credit_buffer #(
  parameter int FLIT_WIDTH         = 128,
  parameter int DEST_WIDTH         = 6,
  parameter int BUFFER_DEPTH       = 4,
  parameter int DOWNSTREAM_CREDITS = 1,
  parameter int NUM_PIPELINE       = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [FLIT_WIDTH-1:0]         data_in,
  input  logic [DEST_WIDTH-1:0]         dest_in,
  input  logic                          is_tail_in,
  input  logic                          send_in,
  output logic                          credit_out,
  output logic [FLIT_WIDTH-1:0]         data_out,
  output logic [DEST_WIDTH-1:0]         dest_out,
  output logic                          is_tail_out,
  output logic                          send_out,
  input  logic                          credit_in,
  output logic [$clog2(BUFFER_DEPTH):0] occupancy,
  output logic                          overflow_err,
  output logic                          credit_err,
  output logic [31:0]                   flit_count,
  output logic [31:0]                   pkt_count
);

  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int OW = PW + 1;
  localparam int CW = $clog2(DOWNSTREAM_CREDITS + 1);
  localparam int EW = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(BUFFER_DEPTH);
  localparam logic [CW-1:0] CRD_MAX  = CW'(DOWNSTREAM_CREDITS);

  logic [EW-1:0]                  mem_q [BUFFER_DEPTH];
  logic [PW-1:0]                  wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]                  occ_q, occ_d;
  logic [CW-1:0]                  crd_q, crd_d;
  logic                           ovf_q, ovf_d;
  logic                           cerr_q, cerr_d;
  logic                           credit_q;
  logic [NUM_PIPELINE:0]          stg_vld_q;
  logic [NUM_PIPELINE:0][EW-1:0]  stg_q;
  logic                           full, pop, push;

  always_comb begin
    full = (occ_q == OCC_FULL);
    pop  = (occ_q != '0) && (crd_q != '0);
    // A full FIFO still accepts a flit when it is popping in the same cycle.
    push = send_in && (!full || pop);

    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;

    crd_d  = crd_q;
    cerr_d = cerr_q;
    if (pop && !credit_in) begin
      crd_d = crd_q - 1'b1;
    end else if (credit_in && !pop) begin
      // Saturate: a credit beyond the downstream buffer size is a protocol error.
      if (crd_q == CRD_MAX) cerr_d = 1'b1;
      else                  crd_d  = crd_q + 1'b1;
    end

    ovf_d = ovf_q | (send_in && full && !pop);
  end

  // Storage is not reset. Validity is tracked by the pointers and occupancy.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {data_in, dest_in, is_tail_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      crd_q    <= CRD_MAX;
      ovf_q    <= 1'b0;
      cerr_q   <= 1'b0;
      credit_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      occ_q    <= occ_d;
      crd_q    <= crd_d;
      ovf_q    <= ovf_d;
      cerr_q   <= cerr_d;
      credit_q <= pop;
    end
  end

  // Stage 0 is the output register loaded by a pop. Later stages only capture
  // payload behind a valid, so the outputs hold their last flit while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld_q <= '0;
      stg_q     <= '0;
    end else begin
      stg_vld_q[0] <= pop;
      if (pop) stg_q[0] <= mem_q[rd_ptr_q];
      for (int k = 1; k <= NUM_PIPELINE; k++) begin
        stg_vld_q[k] <= stg_vld_q[k-1];
        if (stg_vld_q[k-1]) stg_q[k] <= stg_q[k-1];
      end
    end
  end

  assign data_out     = stg_q[NUM_PIPELINE][EW-1 -: FLIT_WIDTH];
  assign dest_out     = stg_q[NUM_PIPELINE][DEST_WIDTH:1];
  assign is_tail_out  = stg_q[NUM_PIPELINE][0];
  assign send_out     = stg_vld_q[NUM_PIPELINE];
  assign credit_out   = credit_q;
  assign occupancy    = occ_q;
  assign overflow_err = ovf_q;
  assign credit_err   = cerr_q;

`ifdef LINK_STATS_EN
  logic [31:0] flit_cnt_q, pkt_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      if (send_out)                flit_cnt_q <= flit_cnt_q + 32'd1;
      if (send_out && is_tail_out) pkt_cnt_q  <= pkt_cnt_q + 32'd1;
    end
  end

  assign flit_count = flit_cnt_q;
  assign pkt_count  = pkt_cnt_q;
`else
  assign flit_count = '0;
  assign pkt_count  = '0;
`endif

endmodule

// File: tb/tb_noc_link_credit_buffer.sv
module tb_noc_link_credit_buffer;

  localparam int FW = 16;
  localparam int DW = 6;
  localparam int BNP = 2;
`ifdef LINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance a: 1 downstream credit, no extra stages
  logic [FW-1:0] a_data, a_dout;
  logic [DW-1:0] a_dest, a_dsto;
  logic a_tail, a_send, a_cin, a_co, a_tailo, a_so, a_ovf, a_cerr;
  logic [2:0] a_occ;
  logic [31:0] a_fc, a_pc;

  // Instance b: 4 downstream credits, two extra stages
  logic [FW-1:0] b_data, b_dout;
  logic [DW-1:0] b_dest, b_dsto;
  logic b_tail, b_send, b_cin, b_co, b_tailo, b_so, b_ovf, b_cerr;
  logic [2:0] b_occ;
  logic [31:0] b_fc, b_pc;

  noc_link_credit_buffer #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .BUFFER_DEPTH(4),
    .DOWNSTREAM_CREDITS(1), .NUM_PIPELINE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_data), .dest_in(a_dest),
    .is_tail_in(a_tail), .send_in(a_send), .credit_out(a_co),
    .data_out(a_dout), .dest_out(a_dsto), .is_tail_out(a_tailo),
    .send_out(a_so), .credit_in(a_cin), .occupancy(a_occ),
    .overflow_err(a_ovf), .credit_err(a_cerr), .flit_count(a_fc), .pkt_count(a_pc));

  noc_link_credit_buffer #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .BUFFER_DEPTH(4),
    .DOWNSTREAM_CREDITS(4), .NUM_PIPELINE(BNP)) u_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_data), .dest_in(b_dest),
    .is_tail_in(b_tail), .send_in(b_send), .credit_out(b_co),
    .data_out(b_dout), .dest_out(b_dsto), .is_tail_out(b_tailo),
    .send_out(b_so), .credit_in(b_cin), .occupancy(b_occ),
    .overflow_err(b_ovf), .credit_err(b_cerr), .flit_count(b_fc), .pkt_count(b_pc));

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [FW-1:0] got_q[$];

  always @(negedge clk) if (rst_n && b_so) got_q.push_back(b_dout);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    a_send = 0; a_data = '0; a_dest = '0; a_tail = 0; a_cin = 0;
    b_send = 0; b_data = '0; b_dest = '0; b_tail = 0; b_cin = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic b_flit(input logic [FW-1:0] d, input logic t);
    b_send = 1; b_data = d; b_dest = 6'h11; b_tail = t;
    @(negedge clk);
    b_send = 0;
  endtask

  task automatic b_credits(input int n);
    for (int i = 0; i < n; i++) begin
      b_cin = 1;
      @(negedge clk);
    end
    b_cin = 0;
  endtask

  // ---------------- directed vector table (instance a) ----------------
  typedef struct {
    logic send; logic [FW-1:0] data; logic tail; logic cin;
    logic e_so; logic [FW-1:0] e_data; logic [DW-1:0] e_dest; logic e_tail;
    logic e_co; logic [2:0] e_occ; logic e_ovf; logic e_cerr;
  } vec_t;

  function automatic vec_t mk(logic s, logic [FW-1:0] d, logic t, logic c,
                              logic eso, logic [FW-1:0] ed, logic [DW-1:0] edst,
                              logic et, logic eco, logic [2:0] eocc, logic ecerr);
    vec_t v;
    v.send = s; v.data = d; v.tail = t; v.cin = c;
    v.e_so = eso; v.e_data = ed; v.e_dest = edst; v.e_tail = et;
    v.e_co = eco; v.e_occ = eocc; v.e_ovf = 1'b0; v.e_cerr = ecerr;
    return v;
  endfunction

  vec_t vecs[11];

  // ---------------- reference model for instance b ----------------
  typedef struct { logic [FW-1:0] d; logic [DW-1:0] dst; logic tl; } flit_t;
  typedef struct { int t; flit_t f; } sched_t;
  flit_t  m_fifo[$];
  sched_t m_sched[$];
  flit_t  m_last;
  int m_cyc, m_crd, up_cr, dn_pend;
  logic m_co, m_ovf, m_cerr;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1, 16'hA001, 0, 0,  0, 16'h0000, 6'h00, 0, 0, 3'd1, 0);
    vecs[1]  = mk(1, 16'hB002, 0, 0,  1, 16'hA001, 6'h05, 0, 1, 3'd1, 0);
    vecs[2]  = mk(1, 16'hC003, 1, 1,  0, 16'hA001, 6'h05, 0, 0, 3'd2, 0);
    vecs[3]  = mk(0, 16'h0000, 0, 0,  1, 16'hB002, 6'h05, 0, 1, 3'd1, 0);
    vecs[4]  = mk(0, 16'h0000, 0, 1,  0, 16'hB002, 6'h05, 0, 0, 3'd1, 0);
    vecs[5]  = mk(0, 16'h0000, 0, 0,  1, 16'hC003, 6'h05, 1, 1, 3'd0, 0);
    vecs[6]  = mk(0, 16'h0000, 0, 1,  0, 16'hC003, 6'h05, 1, 0, 3'd0, 0);
    vecs[7]  = mk(0, 16'h0000, 0, 1,  0, 16'hC003, 6'h05, 1, 0, 3'd0, 1);
    vecs[8]  = mk(1, 16'hD004, 1, 0,  0, 16'hC003, 6'h05, 1, 0, 3'd1, 1);
    vecs[9]  = mk(0, 16'h0000, 0, 0,  1, 16'hD004, 6'h05, 1, 1, 3'd0, 1);
    vecs[10] = mk(0, 16'h0000, 0, 0,  0, 16'hD004, 6'h05, 1, 0, 3'd0, 1);

    idle_inputs();
    repeat (2) @(negedge clk);
    // Reset values while reset is held
    check("rst a send_out", a_so, 0);
    check("rst a credit_out", a_co, 0);
    check("rst a data_out", a_dout, 0);
    check("rst a dest_out", a_dsto, 0);
    check("rst a is_tail_out", a_tailo, 0);
    check("rst a occupancy", a_occ, 0);
    check("rst a overflow_err", a_ovf, 0);
    check("rst a credit_err", a_cerr, 0);
    check("rst a flit_count", a_fc, 0);
    check("rst a pkt_count", a_pc, 0);
    check("rst b send_out", b_so, 0);
    check("rst b occupancy", b_occ, 0);
    rst_n = 1'b1;

    // ---- table: 3-flit packet with one credit, then credit saturation ----
    for (int i = 0; i < 11; i++) begin
      a_send = vecs[i].send; a_data = vecs[i].data; a_dest = 6'h05;
      a_tail = vecs[i].tail; a_cin = vecs[i].cin;
      @(negedge clk);
      check($sformatf("vec%0d send_out", i), a_so, vecs[i].e_so);
      check($sformatf("vec%0d data_out", i), a_dout, vecs[i].e_data);
      check($sformatf("vec%0d dest_out", i), a_dsto, vecs[i].e_dest);
      check($sformatf("vec%0d is_tail_out", i), a_tailo, vecs[i].e_tail);
      check($sformatf("vec%0d credit_out", i), a_co, vecs[i].e_co);
      check($sformatf("vec%0d occupancy", i), a_occ, vecs[i].e_occ);
      check($sformatf("vec%0d overflow_err", i), a_ovf, vecs[i].e_ovf);
      check($sformatf("vec%0d credit_err", i), a_cerr, vecs[i].e_cerr);
    end
    idle_inputs();

    // ---- b: single-flit latency with two extra stages ----
    b_send = 1; b_data = 16'h1234; b_dest = 6'h2A; b_tail = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      b_send = 0;
      check($sformatf("lat k%0d credit_out", k), b_co, (k == 2));
      check($sformatf("lat k%0d send_out", k), b_so, (k == 4));
    end
    check("lat data_out hold", b_dout, 16'h1234);
    check("lat dest_out hold", b_dsto, 6'h2A);
    b_credits(1);

    // ---- b: 8 back-to-back flits, downstream credits withheld ----
    got_q.delete();
    for (int i = 0; i < 8; i++) b_flit(16'h2000 + 16'(i), (i == 7));
    repeat (10) @(negedge clk);
    check("bb8 forwarded before credits", got_q.size(), 4);
    check("bb8 occupancy", b_occ, 4);
    check("bb8 overflow_err", b_ovf, 0);
    b_credits(4);
    repeat (12) @(negedge clk);
    check("bb8 forwarded total", got_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < got_q.size()) check($sformatf("bb8 order %0d", i), got_q[i], 16'h2000 + 16'(i));
    check("bb8 occupancy drained", b_occ, 0);
    check("bb8 credit_err", b_cerr, 0);

    // ---- b: fill at zero credits, fifth flit dropped ----
    got_q.delete();
    for (int i = 0; i < 4; i++) b_flit(16'h3000 + 16'(i), 0);
    check("ovf occupancy full", b_occ, 4);
    check("ovf not yet", b_ovf, 0);
    b_flit(16'h3004, 1);
    check("ovf occupancy stays", b_occ, 4);
    check("ovf flag", b_ovf, 1);
    b_credits(4);
    repeat (12) @(negedge clk);
    check("ovf forwarded count", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) check($sformatf("ovf order %0d", i), got_q[i], 16'h3000 + 16'(i));
    check("ovf flag sticky", b_ovf, 1);

    // ---- b: randomized traffic against the reference model ----
    do_reset();
    m_fifo.delete(); m_sched.delete();
    m_last = '{d: '0, dst: '0, tl: 1'b0};
    m_cyc = 0; m_crd = 4; m_co = 0; m_ovf = 0; m_cerr = 0;
    up_cr = 4; dn_pend = 0;
    for (int it = 0; it < 400; it++) begin
      logic e_so, pop, snd, cin;
      flit_t nf;
      e_so = (m_sched.size() > 0) && (m_sched[0].t == m_cyc);
      if (e_so) m_last = m_sched.pop_front().f;
      check("rnd send_out", b_so, e_so);
      check("rnd data_out", b_dout, m_last.d);
      check("rnd dest_out", b_dsto, m_last.dst);
      check("rnd is_tail_out", b_tailo, m_last.tl);
      check("rnd credit_out", b_co, m_co);
      check("rnd occupancy", b_occ, m_fifo.size());
      check("rnd overflow_err", b_ovf, m_ovf);
      check("rnd credit_err", b_cerr, m_cerr);
      if (e_so) dn_pend++;
      if (m_co) up_cr++;

      snd = (up_cr > 0) && ($urandom_range(0, 99) < 60);
      cin = (dn_pend > 0) && ($urandom_range(0, 99) < 50);
      if (snd) up_cr--;
      if (cin) dn_pend--;
      nf.d = FW'($urandom); nf.dst = DW'($urandom); nf.tl = 1'($urandom);
      b_send = snd; b_data = nf.d; b_dest = nf.dst; b_tail = nf.tl; b_cin = cin;

      // Behavioural step for the coming edge
      pop = (m_fifo.size() > 0) && (m_crd > 0);
      if (pop) m_sched.push_back('{t: m_cyc + 1 + BNP, f: m_fifo.pop_front()});
      if (snd) begin
        if (m_fifo.size() < 4) m_fifo.push_back(nf);
        else m_ovf = 1;
      end
      if (pop && !cin) m_crd--;
      else if (cin && !pop) begin
        if (m_crd == 4) m_cerr = 1;
        else m_crd++;
      end
      m_co = pop;
      m_cyc++;
      @(negedge clk);
    end

    // ---- a: statistics over packets of 2 and 3 flits ----
    do_reset();
    for (int i = 0; i < 25; i++) begin
      a_cin = a_so;
      a_send = (i < 5); a_data = 16'h5000 + 16'(i); a_dest = 6'h07;
      a_tail = (i == 1) || (i == 4);
      @(negedge clk);
    end
    idle_inputs();
    check("stats flit_count", a_fc, STATS ? 5 : 0);
    check("stats pkt_count", a_pc, STATS ? 2 : 0);
    check("stats occupancy", a_occ, 0);
    check("stats credit_err", a_cerr, 0);

    // ---- b: asynchronous reset mid-packet ----
    for (int i = 0; i < 4; i++) b_flit(16'h6000 + 16'(i), (i == 3));
    check("arst pre send_out", b_so, 1);
    check("arst pre occupancy", b_occ, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst b send_out", b_so, 0);
    check("arst b occupancy", b_occ, 0);
    check("arst b credit_out", b_co, 0);
    check("arst b flit_count", b_fc, 0);
    check("arst a flit_count", a_fc, 0);
    check("arst a pkt_count", a_pc, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("arst no credit_out", b_co, 0);
      check("arst no send_out", b_so, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
